// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch and the data memory stage. Data side wins by default, and a
// starvation counter forces fetch ahead after STARVE_MAX data grants.
// Optional bus timeout: define ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYC cycles without mem_ack and raise the sticky arb_err flag.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  generate
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC at least 1");
    end
  endgenerate

  state_t     state;
  state_t     state_next;
  logic [3:0] starve_cnt;
  logic       if_elig;
  logic       dm_elig;
  logic       grant_if;
  logic       grant_dm;
  logic       complete;
  logic       abort;
  logic       tmo_hit;

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant decision in IDLE (done cycle masks a stale request) and completion in BUSY
  always_comb begin
    if_elig    = if_req & ~if_done;
    dm_elig    = dm_req & ~dm_done;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (if_elig && dm_elig && starve_cnt == STARVE_LIM) grant_if = 1'b1;
        else if (dm_elig)                                   grant_dm = 1'b1;
        else if (if_elig)                                   grant_if = 1'b1;
        if (grant_if)      state_next = IF_BUSY;
        else if (grant_dm) state_next = DM_BUSY;
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ack)      complete = 1'b1;
        else if (tmo_hit) abort    = 1'b1;
        if (complete || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory request follows the state; stalls are pure functions of request and done
  always_comb begin
    mem_req  = (state != IDLE);
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end

  // Memory port registers, starvation counter, done pulses and returned read data
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_if) begin
        mem_addr   <= if_addr;
        mem_we     <= 1'b0;
        starve_cnt <= '0;
      end
      if (grant_dm) begin
        mem_addr <= dm_addr;
        mem_we   <= dm_we;
        if (dm_we) mem_wdata <= dm_wdata;
        if (if_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end
      if (complete || abort) begin
        mem_we <= 1'b0;
        if (state == IF_BUSY) begin
          if_done  <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end else begin
          dm_done <= 1'b1;
          if (abort)        dm_rdata <= '0;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Busy-cycle counter, restarted every time the arbiter is idle
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

  // Sticky error flag, only a reset clears it
  always_ff @(posedge clk) begin
    if (rst)        arb_err <= 1'b0;
    else if (abort) arb_err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign arb_err = 1'b0;
`endif

endmodule
